// File: rtl/fifo_pkg.sv
// Shared FIFO constants and width helper, common to the sync and async FIFO generations.
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Ceiling log2, usable in constant expressions for pointer/count widths.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage array: synchronous write, asynchronous read.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [clog2(DEPTH)-1:0]   waddr,
    input  logic [WIDTH-1:0]          wdata,
    input  logic [clog2(DEPTH)-1:0]   raddr,
    output logic [WIDTH-1:0]          rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with selectable standard (registered read) or first-word-fall-through output,
// programmable almost flags, occupancy count and overflow/underflow pulses.
module sync_fifo_fwft
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int FWFT      = FIFO_MODE_STD,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [WIDTH-1:0]        din,
    input  logic                    rd_en,
    output logic [WIDTH-1:0]        dout,
    output logic                    dout_valid,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [clog2(DEPTH):0]   count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int A = clog2(DEPTH);
    localparam logic [A:0] CNT_FULL = (A + 1)'(DEPTH);
    localparam logic [A:0] CNT_AF   = (A + 1)'(AF_THRESH);
    localparam logic [A:0] CNT_AE   = (A + 1)'(AE_THRESH);

    logic [A:0]       wr_ptr_q, wr_ptr_d;
    logic [A:0]       rd_ptr_q, rd_ptr_d;
    logic [A:0]       count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             wr_acc, rd_acc;
    logic [WIDTH-1:0] mem_rdata;

    // Flags decode the registered count only, so they never glitch within a cycle.
    assign full         = (count_q == CNT_FULL);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CNT_AF);
    assign almost_empty = (count_q <= CNT_AE);

    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    always_comb begin
        wr_ptr_d    = wr_ptr_q + (A + 1)'(wr_acc);
        rd_ptr_d    = rd_ptr_q + (A + 1)'(rd_acc);
        count_d     = count_q + (A + 1)'(wr_acc) - (A + 1)'(rd_acc);
        overflow_d  = wr_en & full;
        underflow_d = rd_en & empty;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc & ~rst),
        .waddr (wr_ptr_q[A-1:0]),
        .wdata (din),
        .raddr (rd_ptr_q[A-1:0]),
        .rdata (mem_rdata)
    );

    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    generate
        if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
            assign dout       = mem_rdata;
            assign dout_valid = ~empty;
        end else begin : g_std
            logic [WIDTH-1:0] dout_q, dout_d;
            logic             dout_valid_q, dout_valid_d;

            always_comb begin
                dout_d       = dout_q;
                dout_valid_d = rd_acc;
                if (rd_acc) begin
                    dout_d = mem_rdata;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    dout_q       <= '0;
                    dout_valid_q <= 1'b0;
                end else begin
                    dout_q       <= dout_d;
                    dout_valid_q <= dout_valid_d;
                end
            end

            assign dout       = dout_q;
            assign dout_valid = dout_valid_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Directed bench for sync_fifo_fwft in standard and FWFT modes with a queue-based output scoreboard.
module tb_sync_fifo_fwft;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // standard-mode instance signals
    logic       rst_s = 1'b1, wr_en_s = 1'b0, rd_en_s = 1'b0;
    logic [7:0] din_s = 8'h00, dout_s;
    logic       dv_s, full_s, empty_s, af_s, ae_s, ovf_s, unf_s;
    logic [4:0] count_s;

    // FWFT instance signals
    logic       rst_f = 1'b1, wr_en_f = 1'b0, rd_en_f = 1'b0;
    logic [7:0] din_f = 8'h00, dout_f;
    logic       dv_f, full_f, empty_f, af_f, ae_f, ovf_f, unf_f;
    logic [4:0] count_f;

    sync_fifo_fwft #(.WIDTH(8), .DEPTH(16), .FWFT(0), .AF_THRESH(14), .AE_THRESH(2)) u_std (
        .clk(clk), .rst(rst_s), .wr_en(wr_en_s), .din(din_s), .rd_en(rd_en_s),
        .dout(dout_s), .dout_valid(dv_s), .full(full_s), .empty(empty_s),
        .almost_full(af_s), .almost_empty(ae_s), .count(count_s),
        .overflow(ovf_s), .underflow(unf_s)
    );

    sync_fifo_fwft #(.WIDTH(8), .DEPTH(16), .FWFT(1), .AF_THRESH(14), .AE_THRESH(2)) u_fw (
        .clk(clk), .rst(rst_f), .wr_en(wr_en_f), .din(din_f), .rd_en(rd_en_f),
        .dout(dout_f), .dout_valid(dv_f), .full(full_f), .empty(empty_f),
        .almost_full(af_f), .almost_empty(ae_f), .count(count_f),
        .overflow(ovf_f), .underflow(unf_f)
    );

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_s[$];
    logic [7:0] exp_f[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Standard mode: every dout_valid pulse must carry the oldest outstanding word.
    always @(negedge clk) begin
        if (dv_s === 1'b1) begin
            total++;
            if (exp_s.size() == 0) begin
                bad++;
                $display("FAIL std_dout: unexpected word got=%0h expected=none", dout_s);
            end else begin
                logic [7:0] e;
                e = exp_s.pop_front();
                if (dout_s !== e) begin
                    bad++;
                    $display("FAIL std_dout: got=%0h expected=%0h at %0t", dout_s, e, $time);
                end
            end
        end
    end

    // FWFT mode: the head word is checked when it is popped.
    always @(negedge clk) begin
        if (rd_en_f === 1'b1 && dv_f === 1'b1) begin
            total++;
            if (exp_f.size() == 0) begin
                bad++;
                $display("FAIL fwft_dout: unexpected word got=%0h expected=none", dout_f);
            end else begin
                logic [7:0] e;
                e = exp_f.pop_front();
                if (dout_f !== e) begin
                    bad++;
                    $display("FAIL fwft_dout: got=%0h expected=%0h at %0t", dout_f, e, $time);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---------------- standard mode ----------------
        tick();
        tick();
        rst_s = 1'b0;
        check("rst_count", count_s, 0);
        check("rst_empty", empty_s, 1);
        check("rst_full", full_s, 0);
        check("rst_ae", ae_s, 1);
        check("rst_af", af_s, 0);
        check("rst_dout", dout_s, 8'h00);
        check("rst_dv", dv_s, 0);
        check("rst_ovf", ovf_s, 0);
        check("rst_unf", unf_s, 0);

        // fill 0x01..0x10
        for (int i = 1; i <= 16; i++) begin
            wr_en_s = 1'b1;
            din_s   = 8'(i);
            exp_s.push_back(8'(i));
            tick();
            check("fill_count", count_s, i);
            check("fill_ae", ae_s, (i <= 2) ? 1 : 0);
            check("fill_af", af_s, (i >= 14) ? 1 : 0);
            check("fill_full", full_s, (i == 16) ? 1 : 0);
        end
        din_s = 8'h77;
        tick();
        wr_en_s = 1'b0;
        check("ovf_pulse", ovf_s, 1);
        check("ovf_count", count_s, 16);
        tick();
        check("ovf_clear", ovf_s, 0);

        // drain 16 words
        rd_en_s = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            check("drain_dv", dv_s, 1);
            check("drain_count", count_s, 16 - i);
        end
        check("drain_empty", empty_s, 1);
        tick();
        rd_en_s = 1'b0;
        check("unf_pulse", unf_s, 1);
        check("unf_dv", dv_s, 0);
        check("unf_hold", dout_s, 8'h10);
        tick();
        check("unf_clear", unf_s, 0);
        check("unf_hold2", dout_s, 8'h10);

        // steady state at count 8, pointers wrap past 32
        wr_en_s = 1'b1;
        for (int i = 0; i < 8; i++) begin
            din_s = 8'h20 + 8'(i);
            exp_s.push_back(din_s);
            tick();
        end
        check("steady_pre", count_s, 8);
        rd_en_s = 1'b1;
        for (int i = 8; i < 48; i++) begin
            din_s = 8'h20 + 8'(i);
            exp_s.push_back(din_s);
            tick();
            check("steady_count", count_s, 8);
        end
        wr_en_s = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        rd_en_s = 1'b0;
        tick();
        check("steady_empty", empty_s, 1);
        check("steady_last", dout_s, 8'h4F);

        // full with simultaneous write and read
        wr_en_s = 1'b1;
        for (int i = 0; i < 16; i++) begin
            din_s = 8'h50 + 8'(i);
            exp_s.push_back(din_s);
            tick();
        end
        check("sim_full", full_s, 1);
        din_s   = 8'hEE;
        rd_en_s = 1'b1;
        tick();
        wr_en_s = 1'b0;
        rd_en_s = 1'b0;
        check("sim_ovf", ovf_s, 1);
        check("sim_count", count_s, 15);
        check("sim_dout", dout_s, 8'h50);
        rd_en_s = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        rd_en_s = 1'b0;
        tick();
        check("sim_empty", empty_s, 1);
        check("sim_last", dout_s, 8'h5F);

        // reset mid-stream at count 9
        wr_en_s = 1'b1;
        for (int i = 0; i < 9; i++) begin
            din_s = 8'h60 + 8'(i);
            tick();
        end
        wr_en_s = 1'b0;
        check("mid_count", count_s, 9);
        rst_s   = 1'b1;
        wr_en_s = 1'b1;
        din_s   = 8'hCC;
        tick();
        rst_s   = 1'b0;
        wr_en_s = 1'b0;
        check("mid_rst_count", count_s, 0);
        check("mid_rst_empty", empty_s, 1);
        check("mid_rst_dout", dout_s, 8'h00);
        check("mid_rst_dv", dv_s, 0);
        wr_en_s = 1'b1;
        din_s   = 8'h99;
        exp_s.push_back(8'h99);
        tick();
        wr_en_s = 1'b0;
        rd_en_s = 1'b1;
        tick();
        rd_en_s = 1'b0;
        check("mid_new_dout", dout_s, 8'h99);
        check("mid_new_empty", empty_s, 1);
        tick();

        // ---------------- FWFT mode ----------------
        rst_f = 1'b0;
        check("fw_rst_empty", empty_f, 1);
        check("fw_rst_dv", dv_f, 0);
        check("fw_rst_count", count_f, 0);
        wr_en_f = 1'b1;
        din_f   = 8'hA5;
        exp_f.push_back(8'hA5);
        tick();
        wr_en_f = 1'b0;
        check("fw_a5_dv", dv_f, 1);
        check("fw_a5_dout", dout_f, 8'hA5);
        tick();
        check("fw_a5_hold", dout_f, 8'hA5);
        rd_en_f = 1'b1;
        tick();
        rd_en_f = 1'b0;
        check("fw_pop_empty", empty_f, 1);
        check("fw_pop_dv", dv_f, 0);

        wr_en_f = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din_f = 8'hB0 + 8'(i);
            exp_f.push_back(din_f);
            tick();
        end
        wr_en_f = 1'b0;
        check("fw_head", dout_f, 8'hB0);
        check("fw_count3", count_f, 3);
        rd_en_f = 1'b1;
        tick();
        check("fw_next", dout_f, 8'hB1);
        tick();
        tick();
        check("fw_drained", empty_f, 1);
        tick();
        rd_en_f = 1'b0;
        check("fw_unf", unf_f, 1);
        tick();
        check("fw_unf_clear", unf_f, 0);

        tick();
        check("std_sb_empty", 32'(exp_s.size()), 0);
        check("fw_sb_empty", 32'(exp_f.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sync_fifo_fwft.md
Name: sync_fifo_fwft

Overview:
- Single-clock parametrised FIFO and the next generation of the team's FIFO buffer.
- Adds selectable first-word-fall-through (FWFT) or standard registered-read mode, programmable almost-full/almost-empty thresholds, occupancy count, and overflow/underflow error pulses.
- Used as the intra-domain buffer between pipeline stages and in front of the async FIFO for rate smoothing.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 16, number of entries; power of two, >=2.
- FWFT, 0, 0 = standard mode (registered read, 1-cycle latency); 1 = first-word-fall-through.
- AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH-1.
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH; legal range 0..DEPTH-1.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  write request.
- din  input  WIDTH  write data.
- rd_en  input  1  read request (standard mode) or pop/acknowledge of head word (FWFT).
- dout  output  WIDTH  read data.
- dout_valid  output  1  dout holds a valid word (see Behaviour).
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_THRESH.
- almost_empty  output  1  count <= AE_THRESH.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  output  1  one-cycle pulse: write attempted while full.
- underflow  output  1  one-cycle pulse: read attempted while empty.

Behaviour:
- Reset, sampled on a clk edge with rst=1:
  - wr_ptr = rd_ptr = 0, count = 0, dout = 0, dout_valid = 0, overflow = underflow = 0.
  - Memory contents are not cleared.
  - Resulting flags: empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - rst overrides wr_en/rd_en in the same cycle. Reset mid-operation discards all stored words, and the next cycle behaves as freshly reset.
- Write accept: wr_acc = wr_en & ~full. On accept, mem[wr_ptr[A-1:0]] <= din and wr_ptr increments, where A = $clog2(DEPTH).
- Read accept: rd_acc = rd_en & ~empty. On accept, rd_ptr increments.
- Pointers are A+1 bits wide and wrap naturally modulo 2*DEPTH. The address uses the low A bits.
- count is registered: count <= count + wr_acc - rd_acc.
  - Simultaneous write and read accept leaves count unchanged.
  - When full, only a read can be accepted. When empty, only a write can be accepted. No write-through-when-full and no read-through-when-empty.
- full, empty, almost_full and almost_empty are combinational decodes of the registered count, so they are glitch-free relative to clk.
- Standard mode (FWFT=0):
  - On rd_acc at edge N, dout <= mem[rd_ptr] and is visible after edge N; dout_valid pulses 1 for that one cycle.
  - dout holds its value when there is no rd_acc.
- FWFT mode (FWFT=1):
  - dout = mem[rd_ptr[A-1:0]] (asynchronous read of head); dout_valid = ~empty.
  - A word written at edge N appears on dout after edge N when the FIFO was empty (write-to-visible latency 1 cycle).
  - rd_acc consumes the head, and the next word (if any) appears after the same edge.
  - While empty, dout is don't-care.
- overflow <= wr_en & full; underflow <= rd_en & empty. Both are registered, so each pulse appears the cycle after the offending request. Rejected requests have no other effect.
- Wrap-around: after 2*DEPTH accepted writes, both pointers return to 0. Data order and flags remain correct.

Decomposition:
- Shared package fifo_pkg: constant function clog2 for pointer/count widths, and mode constants FIFO_MODE_STD = 0 and FIFO_MODE_FWFT = 1. These are shared with the async FIFO generation.
- One sub-module, fifo_mem: simple dual-port array, WIDTH x DEPTH, with synchronous write and asynchronous read.
  - The top wraps the asynchronous read in a register for standard mode.
  - Pointer, count and flag logic stays in sync_fifo_fwft.
- Expected RTL size: about 180 lines.

Test Plan (WIDTH=8, DEPTH=16, AF=14, AE=2):
- Reset, then write 0x01..0x10 with no reads -> count steps 1..16; almost_empty drops at count=3; almost_full rises at count=14; full=1 at 16; a 17th wr_en gives an overflow pulse next cycle and count stays 16.
- FIFO full, then read 16 words (FWFT=0) -> dout 0x01..0x10, each one cycle after its rd_en with a dout_valid pulse; empty=1 after the last read; a further rd_en gives an underflow pulse and dout holds 0x10.
- FWFT=1: write 0xA5 into an empty FIFO -> next cycle dout=0xA5, dout_valid=1 with no rd_en; rd_en for one cycle -> empty=1, dout_valid=0.
- Steady state at count=8, wr_en=rd_en=1 for 40 cycles with incrementing data -> count stays 8, output order is exact, and the pointers wrap past 32 without error.
- Full plus simultaneous wr_en and rd_en -> read accepted, write rejected, overflow pulse, count=15.
- Assert rst mid-stream at count=9 -> next cycle count=0, empty=1, dout=0, dout_valid=0; the next write then read returns the new data.
